// File: rtl/axi_tdd_pkg.sv
// Shared types for the TDD sync blocks.
package axi_tdd_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        HOLDOVER = 2'd3
    } sync_mon_state_t;

endpackage

// File: rtl/axi_tdd_sync_window.sv
// Acceptance window around the expected period: lo = max(P-TOL, 1), hi = P+TOL.
module axi_tdd_sync_window #(
    parameter int unsigned SYNC_COUNT_WIDTH = 32,
    parameter int unsigned SYNC_TOLERANCE   = 2
) (
    input  logic [SYNC_COUNT_WIDTH-1:0] period_i,
    input  logic [SYNC_COUNT_WIDTH-1:0] cnt_i,
    output logic                        in_window_o,
    output logic                        early_o,
    output logic                        at_hi_o
);

    localparam logic [SYNC_COUNT_WIDTH:0] TolExt = (SYNC_COUNT_WIDTH + 1)'(SYNC_TOLERANCE);
    localparam logic [SYNC_COUNT_WIDTH:0] OneExt = (SYNC_COUNT_WIDTH + 1)'(1);

    logic [SYNC_COUNT_WIDTH:0] period_ext;
    logic [SYNC_COUNT_WIDTH:0] cnt_ext;
    logic [SYNC_COUNT_WIDTH:0] lo;
    logic [SYNC_COUNT_WIDTH:0] hi;

    // One extra bit so hi never wraps for periods near the counter limit.
    assign period_ext = {1'b0, period_i};
    assign cnt_ext    = {1'b0, cnt_i};
    assign lo         = (period_ext > TolExt) ? period_ext - TolExt : OneExt;
    assign hi         = period_ext + TolExt;

    assign early_o     = cnt_ext < lo;
    assign at_hi_o     = cnt_ext == hi;
    assign in_window_o = !early_o && (cnt_ext <= hi);

endmodule

// File: rtl/axi_tdd_sync_monitor.sv
// Measures incoming TDD sync spacing, locks onto a consistent train and
// regenerates a clean sync that flywheels over missing pulses.
module axi_tdd_sync_monitor
    import axi_tdd_pkg::*;
#(
    parameter int unsigned SYNC_COUNT_WIDTH = 32,
    parameter int unsigned SYNC_TOLERANCE   = 2,
    parameter int unsigned LOCK_COUNT       = 4,
    parameter int unsigned MISS_LIMIT       = 3
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        sync_in,
    input  logic                        tdd_enable,
    input  logic [SYNC_COUNT_WIDTH-1:0] asy_tdd_sync_period,
    output logic                        sync_out,
    output logic                        locked,
    output logic                        sync_early,
    output logic                        sync_missing,
    output logic [SYNC_COUNT_WIDTH-1:0] measured_period
);

    localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MissW  = $clog2(MISS_LIMIT + 1);

    localparam logic [SYNC_COUNT_WIDTH-1:0] CntOne    = SYNC_COUNT_WIDTH'(1);
    localparam logic [SYNC_COUNT_WIDTH-1:0] CntRealign = SYNC_COUNT_WIDTH'(SYNC_TOLERANCE + 1);
    localparam logic [MatchW-1:0]           MatchLock = MatchW'(LOCK_COUNT);
    localparam logic [MissW-1:0]            MissMax   = MissW'(MISS_LIMIT);
    localparam logic [MissW-1:0]            MissOne   = MissW'(1);

    sync_mon_state_t             state_q, state_d;
    logic [SYNC_COUNT_WIDTH-1:0] period_q, period_d;
    logic [SYNC_COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SYNC_COUNT_WIDTH-1:0] meas_q, meas_d;
    logic [MatchW-1:0]           match_q, match_d;
    logic [MissW-1:0]            miss_q, miss_d;
    logic                        first_q, first_d;
    logic                        sync_out_q, sync_out_d;
    logic                        early_q, early_d;
    logic                        missing_q, missing_d;

    logic                        in_window;
    logic                        early;
    logic                        at_hi;
    logic [SYNC_COUNT_WIDTH-1:0] cnt_inc;
    logic [MatchW-1:0]           match_inc;
    logic [MissW-1:0]            miss_next;

    axi_tdd_sync_window #(
        .SYNC_COUNT_WIDTH (SYNC_COUNT_WIDTH),
        .SYNC_TOLERANCE   (SYNC_TOLERANCE)
    ) u_window (
        .period_i    (period_q),
        .cnt_i       (cnt_q),
        .in_window_o (in_window),
        .early_o     (early),
        .at_hi_o     (at_hi)
    );

    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;
    assign match_inc = match_q + MatchW'(1);
    assign miss_next = (state_q == LOCKED) ? MissOne : miss_q + MissOne;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        cnt_d       = cnt_inc;
        meas_d      = meas_q;
        match_d     = match_q;
        miss_d      = miss_q;
        first_d     = first_q;
        sync_out_d  = 1'b0;
        early_d     = 1'b0;
        missing_d   = 1'b0;

        if (!tdd_enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            match_d = '0;
            miss_d  = '0;
            first_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = ACQUIRE;
                    period_d = asy_tdd_sync_period;
                    cnt_d    = '0;
                    match_d  = '0;
                    miss_d   = '0;
                    first_d  = 1'b0;
                end
                ACQUIRE: begin
                    if (sync_in) begin
                        cnt_d   = CntOne;
                        first_d = 1'b1;
                        if (!first_q) begin
                            match_d = '0;
                        end else begin
                            meas_d = cnt_q;
                            if (in_window) begin
                                match_d = match_inc;
                                if (match_inc == MatchLock) begin
                                    state_d = LOCKED;
                                    miss_d  = '0;
                                end
                            end else begin
                                match_d = '0;
                            end
                        end
                    end
                end
                LOCKED, HOLDOVER: begin
                    if (sync_in) begin
                        meas_d = cnt_q;
                        cnt_d  = CntOne;
                        if (in_window) begin
                            sync_out_d = 1'b1;
                            state_d    = LOCKED;
                            miss_d     = '0;
                        end else begin
                            // An early sync becomes the first sync of a fresh acquisition.
                            early_d = early;
                            state_d = ACQUIRE;
                            first_d = 1'b1;
                            match_d = '0;
                        end
                    end else if (at_hi) begin
                        // Substitute lands TOL late, so rewind cnt to the nominal phase.
                        sync_out_d = 1'b1;
                        missing_d  = 1'b1;
                        cnt_d      = CntRealign;
                        miss_d     = miss_next;
                        if (miss_next >= MissMax) begin
                            state_d = ACQUIRE;
                            first_d = 1'b0;
                            match_d = '0;
                        end else begin
                            state_d = HOLDOVER;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            period_q   <= '0;
            cnt_q      <= '0;
            meas_q     <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            first_q    <= 1'b0;
            sync_out_q <= 1'b0;
            early_q    <= 1'b0;
            missing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            meas_q     <= meas_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            first_q    <= first_d;
            sync_out_q <= sync_out_d;
            early_q    <= early_d;
            missing_q  <= missing_d;
        end
    end

    assign sync_out        = sync_out_q;
    assign sync_early      = early_q;
    assign sync_missing    = missing_q;
    assign locked          = (state_q == LOCKED) || (state_q == HOLDOVER);
    assign measured_period = meas_q;

endmodule
